// File: rtl/pcie_hcmd_slot_pool.sv
// rtl/pcie_hcmd_slot_pool.sv - host command slot tag allocator with grouped round-robin search
//
// Hands out free host command slot tags one at a time and takes them back on release.
// The occupancy vector is searched one group per cycle; the group found to hold a free
// slot is then resolved to its lowest free bit, and the tag is offered until taken.
//
// Ports:
//   pcie_user_clk          in   sole clock
//   pcie_user_rst_n        in   asynchronous active-low reset
//   hcmd_slot_rdy          out  a free tag is being offered
//   hcmd_slot_tag          out  the offered tag (stable while rdy is high)
//   hcmd_slot_alloc_en     in   consumer takes the offered tag (ignored unless rdy)
//   hcmd_slot_free_en      in   release request
//   hcmd_slot_invalid_tag  in   tag to release
//   hcmd_slot_used_cnt     out  number of allocated slots
//   hcmd_slot_full         out  every slot is allocated
//   hcmd_slot_free_err     out  one-cycle pulse after an illegal release
module pcie_hcmd_slot_pool #(
    parameter int P_SLOT_WIDTH     = 1024,
    parameter int P_SLOT_TAG_WIDTH = 10,
    parameter int P_GROUP_WIDTH    = 64
) (
    input  logic                        pcie_user_clk,
    input  logic                        pcie_user_rst_n,
    output logic                        hcmd_slot_rdy,
    output logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_tag,
    input  logic                        hcmd_slot_alloc_en,
    input  logic                        hcmd_slot_free_en,
    input  logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_invalid_tag,
    output logic [P_SLOT_TAG_WIDTH:0]   hcmd_slot_used_cnt,
    output logic                        hcmd_slot_full,
    output logic                        hcmd_slot_free_err
);

    localparam int GRP_CNT = P_SLOT_WIDTH / P_GROUP_WIDTH;
    localparam int GRP_W   = $clog2(GRP_CNT);
    localparam int BIT_W   = $clog2(P_GROUP_WIDTH);
    localparam logic [P_SLOT_TAG_WIDTH:0] FULL_CNT = (P_SLOT_TAG_WIDTH+1)'(P_SLOT_WIDTH);

    typedef enum logic [1:0] {
        S_SCAN_GRP = 2'd0,
        S_SCAN_BIT = 2'd1,
        S_GNT      = 2'd2,
        S_FULL     = 2'd3
    } state_t;

    state_t                      state_q,    state_d;
    logic [P_SLOT_WIDTH-1:0]     occ_q,      occ_d;
    logic [P_SLOT_TAG_WIDTH:0]   cnt_q,      cnt_d;
    logic [GRP_W-1:0]            grp_ptr_q,  grp_ptr_d;   // next group the scan starts at
    logic [GRP_W-1:0]            grp_sel_q,  grp_sel_d;   // group latched by the scan
    logic [P_SLOT_TAG_WIDTH-1:0] tag_q,      tag_d;
    logic                        free_err_q, free_err_d;

    logic [P_GROUP_WIDTH-1:0]    ptr_grp_bits;
    logic [P_GROUP_WIDTH-1:0]    sel_grp_bits;
    logic [BIT_W-1:0]            zero_idx;
    logic                        alloc_fire;
    logic                        free_legal;

    // Groups are power-of-two sized, so a group's base tag is its index followed by zeros.
    assign ptr_grp_bits = occ_q[{grp_ptr_q, {BIT_W{1'b0}}} +: P_GROUP_WIDTH];
    assign sel_grp_bits = occ_q[{grp_sel_q, {BIT_W{1'b0}}} +: P_GROUP_WIDTH];

    // Lowest-index zero: walking downwards leaves the smallest hit as the final value.
    always_comb begin
        zero_idx = '0;
        for (int i = P_GROUP_WIDTH - 1; i >= 0; i--) begin
            if (!sel_grp_bits[i]) begin
                zero_idx = BIT_W'(i);
            end
        end
    end

    assign alloc_fire = (state_q == S_GNT) && hcmd_slot_alloc_en;

    // The offered tag's bit is still clear, so releasing it (alone or together with its
    // own alloc) already fails the occupancy test; the explicit compare keeps that
    // guarantee independent of how the offer was formed.
    assign free_legal = hcmd_slot_free_en
                     && occ_q[hcmd_slot_invalid_tag]
                     && !((state_q == S_GNT) && (hcmd_slot_invalid_tag == tag_q));

    always_comb begin
        occ_d = occ_q;
        if (free_legal) begin
            occ_d[hcmd_slot_invalid_tag] = 1'b0;
        end
        if (alloc_fire) begin
            occ_d[tag_q] = 1'b1;
        end

        case ({alloc_fire, free_legal})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        free_err_d = hcmd_slot_free_en && !free_legal;
    end

    always_comb begin
        state_d   = state_q;
        grp_ptr_d = grp_ptr_q;
        grp_sel_d = grp_sel_q;
        tag_d     = tag_q;

        case (state_q)
            S_SCAN_GRP: begin
                if (&ptr_grp_bits) begin
                    grp_ptr_d = grp_ptr_q + 1'b1;
                end else begin
                    grp_sel_d = grp_ptr_q;
                    state_d   = S_SCAN_BIT;
                end
            end
            S_SCAN_BIT: begin
                // Frees since the group scan only add zeros, so a zero is still present.
                tag_d   = {grp_sel_q, zero_idx};
                state_d = S_GNT;
            end
            S_GNT: begin
                if (hcmd_slot_alloc_en) begin
                    grp_ptr_d = grp_sel_q + 1'b1;
                    state_d   = (cnt_d == FULL_CNT) ? S_FULL : S_SCAN_GRP;
                end
            end
            S_FULL: begin
                if (cnt_q != FULL_CNT) begin
                    state_d = S_SCAN_GRP;
                end
            end
            default: state_d = S_SCAN_GRP;
        endcase
    end

    always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
        if (!pcie_user_rst_n) begin
            state_q    <= S_SCAN_GRP;
            occ_q      <= '0;
            cnt_q      <= '0;
            grp_ptr_q  <= '0;
            grp_sel_q  <= '0;
            tag_q      <= '0;
            free_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            cnt_q      <= cnt_d;
            grp_ptr_q  <= grp_ptr_d;
            grp_sel_q  <= grp_sel_d;
            tag_q      <= tag_d;
            free_err_q <= free_err_d;
        end
    end

    assign hcmd_slot_rdy      = (state_q == S_GNT);
    assign hcmd_slot_tag      = tag_q;
    assign hcmd_slot_used_cnt = cnt_q;
    assign hcmd_slot_full     = (cnt_q == FULL_CNT);
    assign hcmd_slot_free_err = free_err_q;

endmodule
